// File: rtl/cpu_onchip_mem_arbiter_pkg.sv
// Shared types and default sizing for the on-chip memory arbiter.
// The state enum tracks whether read data returns in the next cycle.
package cpu_onchip_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 5120;

    typedef enum logic {
        IDLE  = 1'b0,
        RDRET = 1'b1
    } rd_state_t;

endpackage

// File: rtl/cpu_rr_arb2.sv
// Two-requester round-robin grant.
// The grant is combinational; only last_grant is stored.
module cpu_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant;

    // On a conflict the master that did not win last time gets the slot.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            if (&req) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// state | meaning:  IDLE = no read pending,  RDRET = read data returns this coming cycle
module cpu_onchip_mem_arbiter
    import cpu_onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              any_gnt;
    logic              sel;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_read;
    logic              sel_write;
    logic              in_range;
    logic              gnt_rd;
    logic              gnt_wr;

    rd_state_t         state;
    logic              rd_owner;
    logic              rd_oor;
    logic              rd_pending;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    cpu_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );

    assign any_gnt = |grant;
    assign sel     = grant[1];

    always_comb begin
        sel_address    = sel ? m1_address    : m0_address;
        sel_byteenable = sel ? m1_byteenable : m0_byteenable;
        sel_writedata  = sel ? m1_writedata  : m0_writedata;
        sel_read       = sel ? m1_read       : m0_read;
        sel_write      = sel ? m1_write      : m0_write;
    end

    assign in_range = ({1'b0, sel_address} < DEPTH_L);

    // Read together with write counts as a write and produces no return.
    assign gnt_wr = any_gnt & sel_write;
    assign gnt_rd = any_gnt & sel_read & ~sel_write;

    assign mem_address    = any_gnt ? sel_address    : '0;
    assign mem_byteenable = any_gnt ? sel_byteenable : '0;
    assign mem_writedata  = any_gnt ? sel_writedata  : '0;
    assign mem_chipselect = any_gnt & in_range;
    assign mem_write      = gnt_wr & in_range;
    assign mem_clken      = reset_n;

    assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_owner <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            if (gnt_rd) begin
                rd_owner <= sel;
                rd_oor   <= ~in_range;
            end
            case (state)
                IDLE:    if (gnt_rd)  state <= RDRET;
                RDRET:   if (!gnt_rd) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM output is unregistered, so the return cycle samples mem_readdata directly;
    // a write granted in that same cycle cannot disturb it.
    assign rd_pending       = (state == RDRET);
    assign m0_readdatavalid = rd_pending & ~rd_owner;
    assign m1_readdatavalid = rd_pending &  rd_owner;
    assign m0_readdata      = (m0_readdatavalid && !rd_oor) ? mem_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid && !rd_oor) ? mem_readdata : '0;

endmodule
